// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message sequencer and its block buffer.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PAD  = 3'd2,
        ST_SEND = 3'd3,
        ST_WAIT = 3'd4
    } seq_state_e;

    localparam logic [7:0] PAD_BYTE      = 8'h80;
    localparam int         BLOCK_BYTES   = 64;
    localparam int         LEN_FIELD_POS = 56;
    localparam int         BLOCK_WORDS   = 16;

endpackage

// File: rtl/sha256_blk_buf.sv
// 64-byte block buffer: byte-wide write port, big-endian 32-bit word read port.
module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_idx,
    input  logic [7:0]  wr_data,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [7:0] mem_q [BLOCK_BYTES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Lowest byte address lands in the most significant byte of the word.
    always_comb begin
        rd_data = {mem_q[{rd_idx, 2'd0}], mem_q[{rd_idx, 2'd1}],
                   mem_q[{rd_idx, 2'd2}], mem_q[{rd_idx, 2'd3}]};
    end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Byte-stream front end for the SHA-256 core: pads, appends the bit length, streams 512-bit blocks.
// Optional abort input is compiled in when SHA256_SEQ_ABORT_EN is defined.
module sha256_msg_sequencer
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    // Both streams transfer on a cycle where valid and ready are high at the rising edge;
    // a source holds its data stable until that edge, and ready never waits on valid.
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_keep,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic        w_first,
    output logic        w_last,
    input  logic        core_done,
`ifdef SHA256_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        msg_done,
    output logic [2:0]  dbg_state
);

    seq_state_e       state_q, state_d;
    logic [6:0]       pos_q, pos_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [3:0]       word_q, word_d;
    logic             first_pend_q, first_pend_d;
    logic             final_q, final_d;
    logic             marker_q, marker_d;
    logic             zero_tail_q, zero_tail_d;
    logic             pad_pend_q, pad_pend_d;
    logic             busy_q, busy_d;
    logic             msg_done_q, msg_done_d;
    logic             w_valid_q, w_valid_d;
    logic             w_first_q, w_first_d;
    logic             w_last_q, w_last_d;

    logic             in_hs;
    logic             enter_send;
    logic             len_mode;
    logic [LEN_W-1:0] len_bits;
    logic [63:0]      len_field;
    logic [7:0]       len_byte;
    logic             buf_we;
    logic [5:0]       buf_widx;
    logic [7:0]       buf_wdata;

    assign in_ready  = !rst && (state_q == ST_IDLE || state_q == ST_FILL);
    assign in_hs     = in_valid && in_ready;
    assign len_bits  = cnt_q << 3;
    assign len_field = 64'(len_bits);
    assign len_byte  = 8'(len_field >> {~pos_q[2:0], 3'b000});
    // Length goes in the tail only if the 0x80 marker already landed before byte 56.
    assign len_mode  = (pos_q >= 7'(LEN_FIELD_POS)) && marker_q && !zero_tail_q;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        first_pend_d = first_pend_q;
        final_d      = final_q;
        marker_d     = marker_q;
        zero_tail_d  = zero_tail_q;
        pad_pend_d   = pad_pend_q;
        busy_d       = busy_q;
        msg_done_d   = 1'b0;
        w_valid_d    = w_valid_q;
        w_first_d    = w_first_q;
        w_last_d     = w_last_q;
        buf_we       = 1'b0;
        buf_widx     = pos_q[5:0];
        buf_wdata    = in_data;
        enter_send   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    busy_d       = 1'b1;
                    first_pend_d = 1'b1;
                    final_d      = 1'b0;
                    marker_d     = 1'b0;
                    zero_tail_d  = 1'b0;
                    pad_pend_d   = 1'b0;
                    pos_d        = 7'd0;
                    cnt_d        = '0;
                    if (in_keep) begin
                        buf_we   = 1'b1;
                        buf_widx = 6'd0;
                        pos_d    = 7'd1;
                        cnt_d    = LEN_W'(1);
                    end
                    state_d = in_last ? ST_PAD : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_hs) begin
                    if (in_keep) begin
                        buf_we = 1'b1;
                        pos_d  = pos_q + 7'd1;
                        cnt_d  = cnt_q + LEN_W'(1);
                        if (pos_q == 7'(BLOCK_BYTES - 1)) begin
                            // A last byte that fills the block defers all padding to a fresh block.
                            pad_pend_d = in_last;
                            enter_send = 1'b1;
                        end else if (in_last) begin
                            state_d = ST_PAD;
                        end
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                buf_we = 1'b1;
                pos_d  = pos_q + 7'd1;
                if (len_mode) begin
                    buf_wdata = len_byte;
                end else begin
                    buf_wdata = marker_q ? 8'h00 : PAD_BYTE;
                    marker_d  = 1'b1;
                    if (!marker_q && pos_q >= 7'(LEN_FIELD_POS)) begin
                        zero_tail_d = 1'b1;
                    end
                end
                if (pos_q == 7'(BLOCK_BYTES - 1)) begin
                    final_d    = len_mode;
                    pad_pend_d = !len_mode;
                    enter_send = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_ready) begin
                    if (word_q == 4'(BLOCK_WORDS - 1)) begin
                        state_d      = ST_WAIT;
                        w_valid_d    = 1'b0;
                        w_first_d    = 1'b0;
                        w_last_d     = 1'b0;
                        first_pend_d = 1'b0;
                        word_d       = 4'd0;
                    end else begin
                        word_d = word_q + 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    pos_d = 7'd0;
                    if (final_q) begin
                        state_d     = ST_IDLE;
                        msg_done_d  = 1'b1;
                        busy_d      = 1'b0;
                        cnt_d       = '0;
                        final_d     = 1'b0;
                        marker_d    = 1'b0;
                        zero_tail_d = 1'b0;
                        pad_pend_d  = 1'b0;
                    end else if (pad_pend_q) begin
                        state_d     = ST_PAD;
                        pad_pend_d  = 1'b0;
                        zero_tail_d = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_send) begin
            state_d   = ST_SEND;
            word_d    = 4'd0;
            w_valid_d = 1'b1;
            w_first_d = first_pend_q;
            w_last_d  = final_d;
        end

`ifdef SHA256_SEQ_ABORT_EN
        if (abort && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            pos_d        = 7'd0;
            cnt_d        = '0;
            word_d       = 4'd0;
            first_pend_d = 1'b0;
            final_d      = 1'b0;
            marker_d     = 1'b0;
            zero_tail_d  = 1'b0;
            pad_pend_d   = 1'b0;
            busy_d       = 1'b0;
            msg_done_d   = 1'b0;
            w_valid_d    = 1'b0;
            w_first_d    = 1'b0;
            w_last_d     = 1'b0;
            buf_we       = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pos_q        <= 7'd0;
            cnt_q        <= '0;
            word_q       <= 4'd0;
            first_pend_q <= 1'b0;
            final_q      <= 1'b0;
            marker_q     <= 1'b0;
            zero_tail_q  <= 1'b0;
            pad_pend_q   <= 1'b0;
            busy_q       <= 1'b0;
            msg_done_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            w_first_q    <= 1'b0;
            w_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            first_pend_q <= first_pend_d;
            final_q      <= final_d;
            marker_q     <= marker_d;
            zero_tail_q  <= zero_tail_d;
            pad_pend_q   <= pad_pend_d;
            busy_q       <= busy_d;
            msg_done_q   <= msg_done_d;
            w_valid_q    <= w_valid_d;
            w_first_q    <= w_first_d;
            w_last_q     <= w_last_d;
        end
    end

    sha256_blk_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we),
        .wr_idx  (buf_widx),
        .wr_data (buf_wdata),
        .rd_idx  (word_q),
        .rd_data (w_data)
    );

    assign w_valid   = w_valid_q;
    assign w_first   = w_first_q;
    assign w_last    = w_last_q;
    assign busy      = busy_q;
    assign msg_done  = msg_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer: padding model, word scoreboard, core responder, directed messages.
module tb_sha256_msg_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_keep;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        w_first;
    logic        w_last;
    logic        core_done;
    logic        busy;
    logic        msg_done;
    logic [2:0]  dbg_state;
`ifdef SHA256_SEQ_ABORT_EN
    logic        abort;
    initial abort = 1'b0;
`endif

    sha256_msg_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_keep   (in_keep),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_first   (w_first),
        .w_last    (w_last),
        .core_done (core_done),
`ifdef SHA256_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .msg_done  (msg_done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [33:0] exp_q[$];          // {first, last, word}
    logic [7:0]  msg_q[$];
    logic [31:0] got_w [4][16];
    logic        got_first [4];
    logic        got_last [4];
    int          blk_word = 0;
    int          blk_idx = 0;
    int          msgs_done = 0;
    int          stall_cnt = 0;
    int          core_lat = 1;
    int          core_seen = 0;
    bit          bp_arm = 1'b0;
    bit          in_wait = 1'b0;
    bit          wait_final = 1'b0;
    bit          md_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model: padded message -> expected words ----------------
    task automatic model_push(input int n);
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          nblk;
        int          base;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(n) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 16; w++) begin
                base = b * 64 + w * 4;
                exp_q.push_back({(b == 0), (b == nblk - 1),
                                 p[base], p[base + 1], p[base + 2], p[base + 3]});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [7:0] d, input logic l, input logic k);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_keep  = k;
        @(negedge clk);
        while (!in_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL in_handshake: in_ready=0 after %0d cycles, expected 1", guard);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input int n, input bit with_last);
        @(posedge clk);
        #1;
        if (n == 0) begin
            drive_beat(8'h00, 1'b1, 1'b0);
        end else begin
            for (int i = 0; i < n; i++) drive_beat(msg_q[i], with_last && (i == n - 1), 1'b1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_keep  = 1'b1;
    endtask

    task automatic run_msg(input int n, input logic [7:0] base, input int lat);
        int start;
        int guard = 0;
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'(32'(base) + i));
        model_push(n);
        core_lat = lat;
        start = msgs_done;
        send_bytes(n, 1'b1);
        while (msgs_done == start && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        chk("msg_completed", 32'(msgs_done - start), 32'd1);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- core responder ----------------
    initial begin
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                core_seen = 0;
            end else if (w_valid && w_ready) begin
                core_seen++;
                if (core_seen == 16) begin
                    core_seen = 0;
                    repeat (core_lat) @(posedge clk);
                    #1 core_done = 1'b1;
                    @(posedge clk);
                    #1 core_done = 1'b0;
                end
            end
        end
    end

    // ---------------- w_ready backpressure ----------------
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_arm && w_valid && blk_word == 5) begin
                w_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 w_ready = 1'b1;
                bp_arm = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    initial begin
        logic [33:0] e;
        bit          exp_md;
        forever begin
            @(negedge clk);
            if (rst) begin
                blk_word = 0;
                blk_idx  = 0;
                in_wait  = 1'b0;
                md_pend  = 1'b0;
            end else begin
                exp_md  = md_pend;
                md_pend = 1'b0;
                chk("msg_done", 32'(msg_done), 32'(exp_md));
                if (msg_done) chk("busy_at_msg_done", 32'(busy), 32'd0);
                if (in_wait) chk("in_ready_in_wait", 32'(in_ready), 32'd0);
                if (core_done && in_wait) begin
                    md_pend = wait_final;
                    in_wait = 1'b0;
                end
                if (w_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_word: got 0x%08h, expected no word", w_data);
                    end else begin
                        e = exp_q[0];
                        chk($sformatf("w_data b%0d w%0d", blk_idx, blk_word), w_data, e[31:0]);
                        chk($sformatf("w_first b%0d w%0d", blk_idx, blk_word), 32'(w_first), 32'(e[33]));
                        chk($sformatf("w_last b%0d w%0d", blk_idx, blk_word), 32'(w_last), 32'(e[32]));
                        chk("busy_while_sending", 32'(busy), 32'd1);
                        if (!w_ready) begin
                            stall_cnt++;
                        end else begin
                            void'(exp_q.pop_front());
                            if (blk_idx < 4) begin
                                got_w[blk_idx][blk_word] = w_data;
                                got_first[blk_idx]       = w_first;
                                got_last[blk_idx]        = w_last;
                            end
                            blk_word++;
                            if (blk_word == 16) begin
                                blk_word   = 0;
                                blk_idx++;
                                in_wait    = 1'b1;
                                wait_final = e[32];
                            end
                        end
                    end
                end
                if (msg_done) begin
                    msgs_done++;
                    blk_idx = 0;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        int guard;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        in_keep  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_w_valid", 32'(w_valid), 32'd0);
        chk("reset_w_data", w_data, 32'd0);
        chk("reset_w_first", 32'(w_first), 32'd0);
        chk("reset_w_last", 32'(w_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_msg_done", 32'(msg_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // "abc"
        run_msg(3, 8'h61, 1);
        chk("abc_w0", got_w[0][0], 32'h61626380);
        chk("abc_w1", got_w[0][1], 32'h00000000);
        chk("abc_w14", got_w[0][14], 32'h00000000);
        chk("abc_w15", got_w[0][15], 32'h00000018);
        chk("abc_first", 32'(got_first[0]), 32'd1);
        chk("abc_last", 32'(got_last[0]), 32'd1);

        // empty message
        run_msg(0, 8'h00, 2);
        chk("empty_w0", got_w[0][0], 32'h80000000);
        chk("empty_w15", got_w[0][15], 32'h00000000);
        chk("empty_first", 32'(got_first[0]), 32'd1);
        chk("empty_last", 32'(got_last[0]), 32'd1);

        // 56 bytes: marker spills into the length area
        run_msg(56, 8'h00, 3);
        chk("m56_b0_w13", got_w[0][13], 32'h34353637);
        chk("m56_b0_w14", got_w[0][14], 32'h80000000);
        chk("m56_b0_w15", got_w[0][15], 32'h00000000);
        chk("m56_b0_first", 32'(got_first[0]), 32'd1);
        chk("m56_b0_last", 32'(got_last[0]), 32'd0);
        chk("m56_b1_w0", got_w[1][0], 32'h00000000);
        chk("m56_b1_w15", got_w[1][15], 32'h000001C0);
        chk("m56_b1_first", 32'(got_first[1]), 32'd0);
        chk("m56_b1_last", 32'(got_last[1]), 32'd1);

        // 64 bytes with 3-cycle stall at word 5 and slow core
        stall_cnt = 0;
        bp_arm    = 1'b1;
        run_msg(64, 8'h00, 20);
        chk("m64_b0_w5", got_w[0][5], 32'h14151617);
        chk("m64_b0_w15", got_w[0][15], 32'h3C3D3E3F);
        chk("m64_b1_w0", got_w[1][0], 32'h80000000);
        chk("m64_b1_w15", got_w[1][15], 32'h00000200);
        chk("m64_b1_last", 32'(got_last[1]), 32'd1);
        chk("m64_stall_cycles", 32'(stall_cnt), 32'd3);

        // further length boundaries
        run_msg(55, 8'h10, 1);
        chk("m55_w15", got_w[0][15], 32'h000001B8);
        run_msg(63, 8'h40, 4);
        run_msg(120, 8'h05, 2);
        chk("m120_b2_w15", got_w[2][15], 32'h000003C0);

        // reset in the middle of sending block 1 of a 100-byte message
        msg_q.delete();
        for (int i = 0; i < 100; i++) msg_q.push_back(8'(i + 3));
        model_push(100);
        core_lat = 1;
        send_bytes(64, 1'b0);
        guard = 0;
        while (blk_word < 4 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_send_reached", 32'(blk_word >= 4), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_w_valid", 32'(w_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        run_msg(3, 8'h61, 1);
        chk("abc2_w0", got_w[0][0], 32'h61626380);
        chk("abc2_w7", got_w[0][7], 32'h00000000);
        chk("abc2_w15", got_w[0][15], 32'h00000018);
        chk("abc2_first", 32'(got_first[0]), 32'd1);
        chk("abc2_last", 32'(got_last[0]), 32'd1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sequencer.md
# sha256_msg_sequencer

Front-end controller for the SHA-256 compression core. It accepts an arbitrary-length byte stream and performs all padding and length-field insertion. It breaks the padded message into 512-bit blocks, streams each block to the core as 16 big-endian words, and waits for the core's completion pulse before sending the next block. The core itself no longer handles padding; it only sees complete blocks flagged as first and last.

## Interface
- LEN_W, default 64: width of the message bit-length counter. The counter is zero-extended into the 64-bit length field. Legal range is 16..64.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when high together with in_valid
- in_data  in  8  message byte, in order
- in_last  in  1  final byte of the message
- in_keep  in  1  0 = beat carries no byte. Legal only with in_last, giving an empty message.
- w_valid  out  1  block word valid to the core
- w_ready  in  1  core accepts the word
- w_data  out  32  block word, big-endian, word 0 first
- w_first  out  1  high on all 16 words of a message's first block; the core loads the IV
- w_last  out  1  high on all 16 words of a message's final block
- core_done  in  1  one-cycle pulse when the core has finished updating its state for the block
- busy  out  1  a message is in progress
- msg_done  out  1  one-cycle pulse when core_done is seen for the final block

## Operation
- States: IDLE, FILL, PAD, SEND, WAIT.
- IDLE: in_ready=1. An accepted beat sets first_pend and busy, then moves to FILL. If that beat is last, the move goes through the last-byte rule below.
- FILL: in_ready=1. One byte is written per handshake at position pos (0..63), and the byte counter increments by 1.
  - pos reaches 64 and the byte is not last: go to SEND.
  - Last byte: go to PAD.
  - Beat with in_keep=0: the byte is not stored and not counted.
- PAD: writes one byte per cycle.
  - Position n (the first free position) gets 0x80 unless pad_done is set. Later positions get 0x00.
  - n ≤ 55 at pad start: fill through byte 55, write the 8-byte big-endian length {zero-ext, bits} at bytes 56..63, set final, go to SEND.
  - 56 ≤ n ≤ 63: zero-fill through byte 63, set pad_done, go to SEND (not final). After WAIT, return to PAD with pos=0.
  - n == 64 (last byte filled the block): go to SEND first. After WAIT, return to PAD with pos=0 and write 0x80 at byte 0.
- SEND: w_valid=1. Words 0..15 are presented in order, and the word index advances only on w_ready. After word 15 is accepted, go to WAIT and clear first_pend.
- WAIT: in_ready=0, w_valid=0.
  - core_done with final set: pulse msg_done, clear busy, go to IDLE.
  - core_done otherwise: go to PAD if padding is pending, else FILL with pos=0.
- core_done outside WAIT is ignored.
- Length arithmetic: bits = bytes×8 in LEN_W bits, wrapping modulo 2^LEN_W. No error flag.
- Reset outputs: in_ready=0 while rst=1. w_valid=0, w_data=0, w_first=0, w_last=0, busy=0, msg_done=0. State is IDLE, counters and buffer are 0.
- rst mid-message: the partial block and counters are discarded on the next edge. The core must be reset alongside.

## Timing
- in_ready is combinational from state (IDLE/FILL) and gated by !rst. In FILL, throughput is one byte per cycle.
- Word 0 has w_valid high in the cycle after the 64th byte handshake, or in the cycle after the last PAD write.
- w_data, w_first and w_last are stable while w_valid=1 and w_ready=0.
- msg_done is asserted in the cycle after core_done. in_ready rises in that same cycle, so back-to-back messages are allowed.
- Minimum per block: 64 fill cycles + 16 send cycles + core latency.

## Configuration
- SHA256_SEQ_ABORT_EN defined: adds input abort (1 bit).
  - In any state except IDLE, abort=1 returns the block to IDLE next cycle.
  - All counters are cleared, w_valid is dropped, and no msg_done is pulsed.
  - A word already accepted by the core is not recalled. Software must reset the core.
- Not defined: no abort port. Messages always run to completion or until rst.

## Structure
- Shared sha256_pkg holds:
  - the state enum typedef
  - PAD_BYTE=8'h80, BLOCK_BYTES=64, LEN_FIELD_POS=56, BLOCK_WORDS=16
- Sub-module sha256_blk_buf: a 64-byte buffer with a byte-write port (index, data) and a word-read port (index → big-endian 32-bit word). The FSM and counters stay in the top module.

## Test plan
- "abc" (61 62 63, last on 63) → one block: w0=0x61626380, w1..w14=0, w15=0x00000018; w_first=w_last=1; msg_done one cycle after core_done.
- Empty message (in_keep=0, in_last=1) → one block: w0=0x80000000, all others 0; w_first=w_last=1.
- 56 bytes 0x00..0x37 →
  - block 1: w13=0x34353637, w14=0x80000000, w15=0; w_first=1, w_last=0.
  - block 2: w0..w14=0, w15=0x000001C0; w_first=0, w_last=1.
- 64 bytes 0x00..0x3F → block 1 carries the data with w15=0x3C3D3E3F; block 2 has w0=0x80000000, w15=0x00000200, w_last=1.
- Backpressure: w_ready low for 3 cycles at word 5 → w_data holds word 5 and no word is skipped. core_done delayed 20 cycles → in_ready stays 0 throughout WAIT.
- rst asserted mid-SEND on a 100-byte message, then "abc" sent → the next edge shows w_valid=0 and busy=0, and "abc" produces the exact single block from scenario 1.
